tela_titulo_anim: RTL and testbench
===================================

TELA_TITULO_ANIM -- requirements
Module: tela_titulo_anim

Interface
REQ-001 Parameter N_SCALE, default 8, ship sprite pixel scale (integer 1..15).
REQ-002 Parameter E_SCALE, default 10, enemy sprite pixel scale (integer 1..15).
REQ-003 Parameter X_SCALE, default 6, "X" glyph pixel scale (integer 1..15).
REQ-004 Parameter N_POSX/N_POSY, default 250/220, ship final top-left position.
REQ-005 Parameter E_POSX/E_POSY, default 600/220, enemy final top-left position.
REQ-006 Parameter X_POSX/X_POSY, default 445/240, "X" top-left position.
REQ-007 Parameter ANIM_FRAMES, default 30, frames per enemy animation toggle (>=1).
REQ-008 Parameter SLIDE_STEP, default 8, pixels moved per frame during slide-in (>=1).
REQ-009 Parameter FRAME_LINE, default 480, v_counter value that defines the frame tick.
REQ-010 clk  input  1  system clock.
REQ-011 reset  input  1  reset; one clock, asynchronous, active-high.
REQ-012 h_counter  input  10  current pixel column.
REQ-013 v_counter  input  10  current pixel line.
REQ-014 start  input  1  player start button, level, synchronous to clk.
REQ-015 R, G, B  output  8 each  registered pixel colour.
REQ-016 troca  output  1  current enemy animation frame.
REQ-017 done  output  1  title screen finished; held high until reset.

Function
REQ-018 Frame tick SHALL be a one-cycle pulse on the first cycle where h_counter==0 and v_counter==FRAME_LINE (edge-detected, at most one per frame).
REQ-019 R/G/B SHALL be registered: colour for (h_counter,v_counter) appears 1 clk later.
REQ-020 FSM states SLIDE, IDLE, EXIT, DONE; reset enters SLIDE.
REQ-021 SLIDE: ship x starts at 0, enemy x at 639-8*E_SCALE; each tick both move SLIDE_STEP toward final x, clamped (never overshoot); when both equal final, next state IDLE.
REQ-022 start rising edge in SLIDE SHALL snap both x to final and enter IDLE on the next clk.
REQ-023 IDLE: 16-bit frame counter increments per tick; at ANIM_FRAMES-1 it wraps to 0 and troca toggles.
REQ-024 IDLE: start rising edge (registered previous value) SHALL enter EXIT; level-high start held from SLIDE SHALL NOT trigger EXIT.
REQ-025 EXIT: fade shift f starts at 0, increments per tick; output colour = sprite colour >> f; at f==8 enter DONE.
REQ-026 DONE: R/G/B=0, done=1, troca frozen; start ignored.
REQ-027 Ship colour 00/F0/00, 11x11 rows (11-bit, MSB=col 0): 020,070,0F8,1DC,38E,7FF,7FF,7FF,7FF,104,104.
REQ-028 Enemy colour F0/00/00, 8x8 rows (MSB=col 0) 0-4: 3C,7E,FF,CF,FF; rows 5-7 troca=1: 42,A5,5A; troca=0: 24,5A,A5.
REQ-029 "X" colour F0/F0/F0, 5x5 rows: 11,0A,04,0A,11.
REQ-030 Sprite cell = ((counter-pos)/SCALE); pixel inside sprite only if counter in [pos, pos+size*SCALE).
REQ-031 Overlapping sprites SHALL combine by bitwise OR per channel; background 000000.
REQ-032 Ship x below 0 not possible; enemy sprite clipped at column 639 (no wrap).

Reset
REQ-033 Reset SHALL asynchronously force state SLIDE, R/G/B=0, troca=0, done=0, counters and f=0, ship x=0, enemy x=639-8*E_SCALE, start history=0.
REQ-034 Reset asserted mid-EXIT or DONE SHALL return to SLIDE with full brightness on first post-reset frame.

Verification
REQ-035 Reset, run 40 frames defaults -> ship x 0,8,...,248 then 250 (clamped), enemy reaches 600; IDLE entered.
REQ-036 IDLE, ANIM_FRAMES=30 -> troca toggles exactly every 30 ticks; enemy row 5 at pixel (610,270) red only when troca=1.
REQ-037 Pixel (290,220) in IDLE -> G=F0, R=B=0 one clk after counters present it; (289,220) -> 000000.
REQ-038 start pulse in IDLE -> F0 channels read F0,78,3C,1E,0F,07,03,01,00 on successive frames; done=1 after 8th tick.
REQ-039 start held high from reset through SLIDE -> snap to IDLE, no EXIT until start falls and rises again.
REQ-040 Reset asserted async during EXIT frame 4 -> outputs 0 same cycle, done=0, SLIDE restarts with ship x=0.

Source files
------------

// File: rtl/tela_titulo_anim_if.sv
// Raster-side bundle for the title screen animator: the video timing and start
// button go in, the registered pixel colour and status come back.
interface tela_titulo_anim_if;
  // No valid/ready pair: the counters and start are sampled on every clk and
  // R/G/B always carry the colour of the coordinates sampled one clk earlier.
  logic [9:0] h_counter;
  logic [9:0] v_counter;
  logic       start;
  logic [7:0] R;
  logic [7:0] G;
  logic [7:0] B;
  logic       troca;
  logic       done;
  logic [1:0] fsm_state;

  modport master (
    output h_counter, v_counter, start,
    input  R, G, B, troca, done, fsm_state
  );

  modport slave (
    input  h_counter, v_counter, start,
    output R, G, B, troca, done, fsm_state
  );
endinterface

// File: rtl/tela_titulo_anim.sv
// Title screen: ship and enemy slide in, enemy animates until start, then the
// whole picture fades out by one bit per frame and the screen reports done.
module tela_titulo_anim #(
  parameter int N_SCALE     = 8,
  parameter int E_SCALE     = 10,
  parameter int X_SCALE     = 6,
  parameter int N_POSX      = 250,
  parameter int N_POSY      = 220,
  parameter int E_POSX      = 600,
  parameter int E_POSY      = 220,
  parameter int X_POSX      = 445,
  parameter int X_POSY      = 240,
  parameter int ANIM_FRAMES = 30,
  parameter int SLIDE_STEP  = 8,
  parameter int FRAME_LINE  = 480
) (
  input logic clk,
  input logic reset,
  tela_titulo_anim_if.slave bus
);

  localparam logic [1:0] S_SLIDE = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_EXIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [9:0]  N_X     = 10'(N_POSX);
  localparam logic [9:0]  E_X     = 10'(E_POSX);
  localparam logic [9:0]  X_X     = 10'(X_POSX);
  localparam logic [9:0]  E_START = 10'(639 - 8 * E_SCALE);
  localparam logic [9:0]  STEP    = 10'(SLIDE_STEP);
  localparam logic [9:0]  F_LINE  = 10'(FRAME_LINE);
  localparam logic [15:0] F_LAST  = 16'(ANIM_FRAMES - 1);

  localparam logic [10:0] N_Y11 = 11'(N_POSY);
  localparam logic [10:0] E_Y11 = 11'(E_POSY);
  localparam logic [10:0] X_Y11 = 11'(X_POSY);
  localparam logic [10:0] N_SC  = 11'(N_SCALE);
  localparam logic [10:0] E_SC  = 11'(E_SCALE);
  localparam logic [10:0] X_SC  = 11'(X_SCALE);
  localparam logic [10:0] N_SZ  = 11'(11 * N_SCALE);
  localparam logic [10:0] E_SZ  = 11'(8 * E_SCALE);
  localparam logic [10:0] X_SZ  = 11'(5 * X_SCALE);

  logic [1:0]  state;
  logic [9:0]  ship_x;
  logic [9:0]  enemy_x;
  logic [15:0] frame_cnt;
  logic [3:0]  fade;
  logic        start_q;
  logic        line_q;
  logic        troca_r;
  logic        done_r;
  logic [7:0]  r_q, g_q, b_q;

  logic line_hit;
  logic tick;
  logic rise;

  assign line_hit = (bus.h_counter == 10'd0) && (bus.v_counter == F_LINE);
  assign tick     = line_hit && !line_q;
  assign rise     = bus.start && !start_q;

  function automatic logic [9:0] step_to(input logic [9:0] cur, input logic [9:0] tgt);
    if (cur < tgt)      return (tgt - cur > STEP) ? cur + STEP : tgt;
    else if (cur > tgt) return (cur - tgt > STEP) ? cur - STEP : tgt;
    else                return cur;
  endfunction

  function automatic logic [10:0] ship_row(input logic [3:0] r);
    case (r)
      4'd0:    return 11'h020;
      4'd1:    return 11'h070;
      4'd2:    return 11'h0F8;
      4'd3:    return 11'h1DC;
      4'd4:    return 11'h38E;
      4'd5:    return 11'h7FF;
      4'd6:    return 11'h7FF;
      4'd7:    return 11'h7FF;
      4'd8:    return 11'h7FF;
      4'd9:    return 11'h104;
      4'd10:   return 11'h104;
      default: return 11'h000;
    endcase
  endfunction

  // Rows 5-7 carry the two leg poses selected by troca.
  function automatic logic [7:0] enemy_row(input logic [2:0] r, input logic alt);
    case (r)
      3'd0:    return 8'h3C;
      3'd1:    return 8'h7E;
      3'd2:    return 8'hFF;
      3'd3:    return 8'hCF;
      3'd4:    return 8'hFF;
      3'd5:    return alt ? 8'h42 : 8'h24;
      3'd6:    return alt ? 8'hA5 : 8'h5A;
      default: return alt ? 8'h5A : 8'hA5;
    endcase
  endfunction

  function automatic logic [4:0] x_row(input logic [2:0] r);
    case (r)
      3'd0:    return 5'h11;
      3'd1:    return 5'h0A;
      3'd2:    return 5'h04;
      3'd3:    return 5'h0A;
      3'd4:    return 5'h11;
      default: return 5'h00;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_SLIDE;
      ship_x    <= 10'd0;
      enemy_x   <= E_START;
      frame_cnt <= 16'd0;
      fade      <= 4'd0;
      start_q   <= 1'b0;
      line_q    <= 1'b0;
      troca_r   <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      start_q <= bus.start;
      line_q  <= line_hit;
      case (state)
        S_SLIDE: begin
          if (rise) begin
            ship_x  <= N_X;
            enemy_x <= E_X;
            state   <= S_IDLE;
          end else if (ship_x == N_X && enemy_x == E_X) begin
            state <= S_IDLE;
          end else if (tick) begin
            ship_x  <= step_to(ship_x, N_X);
            enemy_x <= step_to(enemy_x, E_X);
          end
        end
        S_IDLE: begin
          if (rise) begin
            fade  <= 4'd0;
            state <= S_EXIT;
          end else if (tick) begin
            if (frame_cnt == F_LAST) begin
              frame_cnt <= 16'd0;
              troca_r   <= ~troca_r;
            end else begin
              frame_cnt <= frame_cnt + 16'd1;
            end
          end
        end
        S_EXIT: begin
          if (fade == 4'd8) begin
            state  <= S_DONE;
            done_r <= 1'b1;
          end else if (tick) begin
            fade <= fade + 4'd1;
          end
        end
        default: done_r <= 1'b1;
      endcase
    end
  end

  logic [10:0] n_dx, n_dy, e_dx, e_dy, x_dx, x_dy;
  logic        n_in, e_in, x_in;
  logic [3:0]  n_col, n_row;
  logic [2:0]  e_col, e_row, x_col, x_row_i;
  logic [10:0] n_bits;
  logic [7:0]  e_bits;
  logic [4:0]  x_bits;
  logic        n_on, e_on, x_on;
  logic [7:0]  r_c, g_c, b_c;

  // Offsets are only meaningful when the counter is at or past the sprite
  // origin; the range checks guard the wrapped differences.
  always_comb begin
    n_dx = {1'b0, bus.h_counter} - {1'b0, ship_x};
    n_dy = {1'b0, bus.v_counter} - N_Y11;
    e_dx = {1'b0, bus.h_counter} - {1'b0, enemy_x};
    e_dy = {1'b0, bus.v_counter} - E_Y11;
    x_dx = {1'b0, bus.h_counter} - {1'b0, X_X};
    x_dy = {1'b0, bus.v_counter} - X_Y11;

    n_in = (bus.h_counter >= ship_x) && (n_dx < N_SZ) &&
           ({1'b0, bus.v_counter} >= N_Y11) && (n_dy < N_SZ);
    e_in = (bus.h_counter >= enemy_x) && (e_dx < E_SZ) &&
           (bus.h_counter <= 10'd639) &&
           ({1'b0, bus.v_counter} >= E_Y11) && (e_dy < E_SZ);
    x_in = (bus.h_counter >= X_X) && (x_dx < X_SZ) &&
           ({1'b0, bus.v_counter} >= X_Y11) && (x_dy < X_SZ);

    n_col   = 4'(n_dx / N_SC);
    n_row   = 4'(n_dy / N_SC);
    e_col   = 3'(e_dx / E_SC);
    e_row   = 3'(e_dy / E_SC);
    x_col   = 3'(x_dx / X_SC);
    x_row_i = 3'(x_dy / X_SC);

    n_bits = ship_row(n_row);
    e_bits = enemy_row(e_row, troca_r);
    x_bits = x_row(x_row_i);

    n_on = n_in && n_bits[4'd10 - n_col];
    e_on = e_in && e_bits[3'd7 - e_col];
    x_on = x_in && x_bits[3'd4 - x_col];

    r_c = (e_on || x_on) ? 8'hF0 : 8'h00;
    g_c = (n_on || x_on) ? 8'hF0 : 8'h00;
    b_c = x_on ? 8'hF0 : 8'h00;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= 8'h00;
      g_q <= 8'h00;
      b_q <= 8'h00;
    end else if (state == S_DONE) begin
      r_q <= 8'h00;
      g_q <= 8'h00;
      b_q <= 8'h00;
    end else begin
      r_q <= r_c >> fade;
      g_q <= g_c >> fade;
      b_q <= b_c >> fade;
    end
  end

  assign bus.R         = r_q;
  assign bus.G         = g_q;
  assign bus.B         = b_q;
  assign bus.troca     = troca_r;
  assign bus.done      = done_r;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_tela_titulo_anim.sv
// Directed bench for the title screen: a frame-level model predicts every
// registered pixel, troca and done; literal checks pin key screen points.
module tb_tela_titulo_anim;

  localparam int NS = 8, ES = 10, XS = 6;
  localparam int NPX = 250, NPY = 220, EPX = 600, EPY = 220, XPX = 445, XPY = 240;
  localparam int AF = 30, STEP = 8, FL = 480;
  localparam int M_SLIDE = 0, M_IDLE = 1, M_EXIT = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tela_titulo_anim_if bus();

  tela_titulo_anim #(
    .N_SCALE(NS), .E_SCALE(ES), .X_SCALE(XS),
    .N_POSX(NPX), .N_POSY(NPY), .E_POSX(EPX), .E_POSY(EPY),
    .X_POSX(XPX), .X_POSY(XPY), .ANIM_FRAMES(AF), .SLIDE_STEP(STEP),
    .FRAME_LINE(FL)
  ) dut (
    .clk(clk),
    .reset(rst),
    .bus(bus)
  );

  logic [10:0] ship_tab [11] = '{11'h020, 11'h070, 11'h0F8, 11'h1DC, 11'h38E,
                                 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h104, 11'h104};
  logic [7:0]  en_top [5]    = '{8'h3C, 8'h7E, 8'hFF, 8'hCF, 8'hFF};
  logic [7:0]  en_alt1 [3]   = '{8'h42, 8'hA5, 8'h5A};
  logic [7:0]  en_alt0 [3]   = '{8'h24, 8'h5A, 8'hA5};
  logic [4:0]  x_tab [5]     = '{5'h11, 5'h0A, 5'h04, 5'h0A, 5'h11};
  logic [7:0]  fade_tab [9]  = '{8'hF0, 8'h78, 8'h3C, 8'h1E, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};

  int   n_checks = 0;
  int   n_fail   = 0;
  logic st_lvl;

  // {R, G, B, troca, done}
  logic [25:0] exp_q[$];

  int   m_state, m_ship, m_enemy, m_f, m_idle_ticks;
  logic m_prev_st, m_prev_match;

  function automatic logic m_troca();
    return ((m_idle_ticks / AF) % 2) == 1;
  endfunction

  task automatic model_reset();
    m_state      = M_SLIDE;
    m_ship       = 0;
    m_enemy      = 639 - 8 * ES;
    m_f          = 0;
    m_idle_ticks = 0;
    m_prev_st    = 1'b0;
    m_prev_match = 1'b0;
  endtask

  function automatic logic [23:0] model_px(input int h, input int v);
    int r = 0, g = 0, b = 0;
    int col, row;
    logic [7:0] bits;
    if (m_state == M_DONE) return 24'h0;
    if (h >= m_ship && h < m_ship + 11 * NS && v >= NPY && v < NPY + 11 * NS) begin
      col = (h - m_ship) / NS;
      row = (v - NPY) / NS;
      if (ship_tab[row][10 - col]) g = 'hF0;
    end
    if (h <= 639 && h >= m_enemy && h < m_enemy + 8 * ES && v >= EPY && v < EPY + 8 * ES) begin
      col  = (h - m_enemy) / ES;
      row  = (v - EPY) / ES;
      bits = (row < 5) ? en_top[row] : (m_troca() ? en_alt1[row - 5] : en_alt0[row - 5]);
      if (bits[7 - col]) r = 'hF0;
    end
    if (h >= XPX && h < XPX + 5 * XS && v >= XPY && v < XPY + 5 * XS) begin
      col = (h - XPX) / XS;
      row = (v - XPY) / XS;
      if (x_tab[row][4 - col]) begin
        r = 'hF0; g = 'hF0; b = 'hF0;
      end
    end
    return {8'(r >> m_f), 8'(g >> m_f), 8'(b >> m_f)};
  endfunction

  task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: drive one vector, predict what the next edge yields.
  task automatic present(input int h, input int v);
    logic [23:0] pix;
    logic match, tick, rise;
    bus.h_counter = 10'(h);
    bus.v_counter = 10'(v);
    bus.start     = st_lvl;
    pix   = model_px(h, v);
    match = (h == 0) && (v == FL);
    tick  = match && !m_prev_match;
    rise  = st_lvl && !m_prev_st;
    m_prev_match = match;
    m_prev_st    = st_lvl;
    case (m_state)
      M_SLIDE: begin
        if (rise) begin
          m_ship = NPX; m_enemy = EPX; m_state = M_IDLE;
        end else if (m_ship == NPX && m_enemy == EPX) begin
          m_state = M_IDLE;
        end else if (tick) begin
          m_ship  = (m_ship + STEP > NPX) ? NPX : m_ship + STEP;
          if (m_enemy < EPX) m_enemy = (m_enemy + STEP > EPX) ? EPX : m_enemy + STEP;
          else               m_enemy = (m_enemy - STEP < EPX) ? EPX : m_enemy - STEP;
        end
      end
      M_IDLE: begin
        if (rise) begin
          m_f = 0; m_state = M_EXIT;
        end else if (tick) begin
          m_idle_ticks++;
        end
      end
      M_EXIT: begin
        if (m_f == 8) m_state = M_DONE;
        else if (tick) m_f++;
      end
      default: ;
    endcase
    exp_q.push_back({pix, m_troca(), m_state == M_DONE});
    @(negedge clk);
  endtask

  task automatic frame();
    present(0, FL);
    present(1, FL);
    present(m_ship + 40, NPY);
    present(m_enemy + 25, EPY + 50);
    present(int'($urandom_range(700, 230)), int'($urandom_range(330, 210)));
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic lit(input string name, input int h, input int v, input logic [23:0] exp);
    present(h, v);
    check(name, 26'({bus.R, bus.G, bus.B}), 26'(exp));
  endtask

  task automatic pulse_start();
    st_lvl = 1'b1;
    present(5, 5);
    st_lvl = 1'b0;
    present(5, 5);
  endtask

  // Called at a negedge; reset lands mid-cycle, away from either edge.
  task automatic do_reset(input string name);
    #3;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check(name, {bus.R, bus.G, bus.B, bus.troca, bus.done}, 26'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      logic [25:0] e;
      e = exp_q.pop_front();
      check("cycle_model", {bus.R, bus.G, bus.B, bus.troca, bus.done}, e);
    end
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected end of sequence");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    rst = 1'b1;
    st_lvl = 1'b0;
    bus.h_counter = 10'd0;
    bus.v_counter = 10'd0;
    bus.start = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_state", {bus.R, bus.G, bus.B, bus.troca, bus.done}, 26'h0);
    rst = 1'b0;

    // Slide-in: 31 ticks puts the ship at 248, the 32nd clamps it to 250.
    frames(31);
    lit("ship_at_248", 288, 220, 24'h00F000);
    lit("ship_at_248_left", 287, 220, 24'h000000);
    lit("enemy_at_600", 620, 220, 24'hF00000);
    frames(1);
    lit("ship_290_220", 290, 220, 24'h00F000);
    lit("ship_289_220", 289, 220, 24'h000000);
    frames(8);
    lit("enemy_col_639", 639, 260, 24'hF00000);
    lit("enemy_clip_640", 640, 260, 24'h000000);

    // Animation: 40 frames done, 8 of them in IDLE.
    frames(21);
    check("troca_idle29", 26'(bus.troca), 26'd0);
    lit("enemy_row5_t0", 610, 270, 24'h000000);
    frames(1);
    check("troca_idle30", 26'(bus.troca), 26'd1);
    lit("enemy_row5_t1", 610, 270, 24'hF00000);
    frames(29);
    check("troca_idle59", 26'(bus.troca), 26'd1);
    frames(1);
    check("troca_idle60", 26'(bus.troca), 26'd0);

    // Fade out on a start pulse.
    pulse_start();
    for (int k = 0; k < 9; k++) begin
      lit($sformatf("fade_%0d", k), 290, 220, {8'h00, fade_tab[k], 8'h00});
      if (k < 8) frame();
    end
    check("done_after_fade", 26'(bus.done), 26'd1);
    pulse_start();
    frames(2);
    check("done_held", 26'(bus.done), 26'd1);
    check("troca_frozen", 26'(bus.troca), 26'd0);
    lit("done_black", 290, 220, 24'h000000);

    // Reset out of DONE, snap to IDLE, exit, then reset four ticks into the fade.
    do_reset("reset_from_done");
    pulse_start();
    lit("snap_idle", 290, 220, 24'h00F000);
    pulse_start();
    frames(4);
    lit("exit_f4", 290, 220, 24'h000F00);
    do_reset("reset_mid_exit");
    lit("ship_x0_full", 40, 220, 24'h00F000);
    lit("enemy_start", 579, 220, 24'hF00000);
    lit("enemy_start_gap", 620, 220, 24'h000000);
    check("done_after_reset", 26'(bus.done), 26'd0);

    // Start held from reset: snap only, no exit until it is released and pressed again.
    st_lvl = 1'b1;
    do_reset("reset_start_held");
    present(5, 5);
    frames(3);
    lit("held_no_exit", 290, 220, 24'h00F000);
    check("held_not_done", 26'(bus.done), 26'd0);
    st_lvl = 1'b0;
    present(5, 5);
    st_lvl = 1'b1;
    present(5, 5);
    frame();
    lit("repress_exit", 290, 220, 24'h007800);
    st_lvl = 1'b0;
    frames(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
